clock_period_meter: RTL and testbench
=====================================

# clock_period_meter

Measures the high-phase and low-phase lengths of a slow clock-like input, counted in `clk` cycles, and publishes one measurement per full period. It is the receive-side counterpart of the programmable clock divider. It checks back a generated `divClk`, or any externally supplied slow strobe clock, against the programmed high and low counts. It also flags lock, meaning a stable repeating period, and stuck, meaning no edge within the counter range.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser flops on `measClk`. 0 is legal and means the input is already in the `clk` domain.
- `LOCK_PERIODS`, default 4: number of consecutive matching publications required for `locked`. Range 1..15.
- `TOL`, default 0: allowed absolute difference per phase count between consecutive publications that still counts as a match.

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-low reset
- `measClk`  in  1  signal under measurement
- `highCount`  out  16  last published high-phase length, in clk cycles
- `lowCount`  out  16  last published low-phase length, in clk cycles
- `period`  out  17  last published `highCount + lowCount`, zero-extended, no overflow
- `valid`  out  1  one-cycle pulse when new counts are published
- `locked`  out  1  stable period detected
- `stuck`  out  1  a phase exceeded 65535 cycles

## Operation
- **Signals.** `s` is `measClk` after `SYNC_STAGES` flops. `s_d` is `s` delayed by one cycle, and resets to 1.
  - rise = `s & ~s_d`; fall = `~s & s_d`.
  - Because `s_d` resets to 1, an input that is high at reset release produces no rise.
- **State machine.** States: IDLE, HIGH, LOW.
  - IDLE: wait for a rise. On a rise, go to HIGH with `hcnt`=1, no publication, and `stuck`<=0.
  - HIGH: each cycle with `s`=1, `hcnt` increments. On a fall, go to LOW with `lcnt`=1.
  - LOW: each cycle with `s`=0, `lcnt` increments. On a rise:
    - `highCount`<=`hcnt`, `lowCount`<=`lcnt`, `period`<=sum, `valid`<=1;
    - `hcnt`<=1; stay in HIGH.
  - Result: a waveform high for H samples and low for L samples publishes exactly H and L.
- **Saturation / stuck.** If `hcnt` (in HIGH) or `lcnt` (in LOW) is 0xFFFF and the sample keeps the same level:
  - `stuck`<=1, `locked`<=0, match count<=0, go to IDLE;
  - published counts hold.
- **Lock.** On each publication, compare against the previous publication: |ΔH|<=`TOL` and |ΔL|<=`TOL`.
  - Match: match count increments, saturating at `LOCK_PERIODS`.
  - Mismatch: match count<=0 and `locked`<=0.
  - `locked`<=1 when the match count reaches `LOCK_PERIODS`.
  - The first publication after IDLE has no predecessor, so it sets match count to 0.
- **Priority.** Reset overrides everything. Stuck overrides publication, though the two cannot coincide because a publication requires an edge. `valid` and the `locked` change occur in the same cycle.
- **Arithmetic.** Counters are 16-bit unsigned and saturating. Tolerance comparison uses 17-bit signed differences.

## Timing
- **Reset.** While `rst`=0 at a clk edge:
  - all outputs become 0;
  - state goes to IDLE;
  - sync flops go to 0, and `s_d` goes to 1.
  - Reset mid-measurement discards partial counts. The next publication needs two rises after release.
- **Latency.** `valid` asserts `SYNC_STAGES`+1 cycles after the `measClk` sample that is the rising edge. It lasts exactly one cycle.
- **Counts.**
  - `highCount`, `lowCount` and `period` change only in the `valid` cycle and are stable otherwise.
  - `stuck` changes the cycle after the 65536th identical sample. It clears on the cycle after the rise in IDLE.
- **Throughput.** The minimum input is 1 high and 1 low, giving `valid` every 2 cycles.
- **Publication timing.** The first publication occurs at the second qualifying rise after reset or stuck.

## Test plan
- **Reset.** Hold `rst`=0 for 3 cycles with `measClk` toggling → all outputs 0, no `valid`.
- **Basic period.** Input 3 high / 5 low, repeating, `SYNC_STAGES`=2 → first `valid` at the second rise, `highCount`=3, `lowCount`=5, `period`=8. Thereafter `valid` pulses every 8 cycles.
- **Lock.** Same pattern with `LOCK_PERIODS`=4, `TOL`=0 → `locked`=1 on the 5th publication. Switch to 4 high / 5 low → `locked`=0 on that publication, then relock 4 publications later. With `TOL`=1, `locked` stays 1 across the switch.
- **Stuck.** Hold `measClk`=1 for 70000 cycles after a rise:
  - `stuck`=1 and `locked`=0 after 65536 high samples;
  - then 4 low, rise → `stuck`=0, no `valid`;
  - next rise publishes the true counts.
- **Edge cases.**
  - `measClk` high at reset release → no rise until after it falls; the first HIGH starts at the genuine rise.
  - 1 high / 1 low → 1, 1, period 2.
- **Mid-measurement reset.** Pulse `rst` low for one cycle during a LOW phase → outputs 0 the next cycle, then two rises are needed before the next `valid`.

Source files
------------

// File: rtl/clock_period_meter.sv
// Measures high/low phase lengths of a slow input in clk cycles, publishing one
// measurement per full period with lock (stable period) and stuck (no edge) flags.
module clock_period_meter #(
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_PERIODS = 4,
  parameter int TOL          = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        measClk,
  output logic [15:0] highCount,
  output logic [15:0] lowCount,
  output logic [16:0] period,
  output logic        valid,
  output logic        locked,
  output logic        stuck
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [16:0] TOL_L  = 17'(TOL);
  localparam logic [3:0]  LOCK_L = 4'(LOCK_PERIODS);

  logic s;
  logic primed;
  logic s_d_q;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s      = measClk;
      assign primed = 1'b1;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES-1:0] prime_q;
      always_ff @(posedge clk) begin
        if (!rst) begin
          sync_q  <= '0;
          prime_q <= '0;
        end else begin
          sync_q  <= SYNC_STAGES'({sync_q, measClk});
          prime_q <= SYNC_STAGES'({prime_q, 1'b1});
        end
      end
      assign s      = sync_q[SYNC_STAGES-1];
      // s_d stays high until reset-zeroed stages drain, so a high-at-release input gives no rise
      assign primed = prime_q[SYNC_STAGES-1];
    end
  endgenerate

  logic rise;
  logic fall;
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  state_t      state_q;
  logic [15:0] hcnt_q;
  logic [15:0] lcnt_q;
  logic [15:0] high_q;
  logic [15:0] low_q;
  logic [16:0] period_q;
  logic        valid_q;
  logic        locked_q;
  logic        stuck_q;
  logic [3:0]  match_q;
  logic        have_prev_q;

  // Tolerance check against the previous publication, 17-bit signed differences
  logic [16:0] dh;
  logic [16:0] dl;
  logic [16:0] abs_h;
  logic [16:0] abs_l;
  logic        tol_ok;
  assign dh     = {1'b0, hcnt_q} - {1'b0, high_q};
  assign dl     = {1'b0, lcnt_q} - {1'b0, low_q};
  assign abs_h  = dh[16] ? (17'd0 - dh) : dh;
  assign abs_l  = dl[16] ? (17'd0 - dl) : dl;
  assign tol_ok = (abs_h <= TOL_L) && (abs_l <= TOL_L);

  logic [3:0] match_d;
  logic       locked_d;
  always_comb begin
    match_d  = match_q;
    locked_d = locked_q;
    if (!have_prev_q) begin
      match_d = 4'd0;
    end else if (tol_ok) begin
      if (match_q != LOCK_L) match_d = match_q + 4'd1;
      if (match_d == LOCK_L) locked_d = 1'b1;
    end else begin
      match_d  = 4'd0;
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      s_d_q       <= 1'b1;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      high_q      <= '0;
      low_q       <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      stuck_q     <= 1'b0;
      match_q     <= '0;
      have_prev_q <= 1'b0;
    end else begin
      s_d_q   <= primed ? s : 1'b1;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= HIGH;
            hcnt_q  <= 16'd1;
            stuck_q <= 1'b0;
          end
        end
        HIGH: begin
          if (fall) begin
            state_q <= LOW;
            lcnt_q  <= 16'd1;
          end else if (s) begin
            if (hcnt_q == 16'hFFFF) begin
              stuck_q     <= 1'b1;
              locked_q    <= 1'b0;
              match_q     <= '0;
              have_prev_q <= 1'b0;
              state_q     <= IDLE;
            end else begin
              hcnt_q <= hcnt_q + 16'd1;
            end
          end
        end
        LOW: begin
          if (rise) begin
            high_q      <= hcnt_q;
            low_q       <= lcnt_q;
            period_q    <= {1'b0, hcnt_q} + {1'b0, lcnt_q};
            valid_q     <= 1'b1;
            match_q     <= match_d;
            locked_q    <= locked_d;
            have_prev_q <= 1'b1;
            hcnt_q      <= 16'd1;
            state_q     <= HIGH;
          end else if (!s) begin
            if (lcnt_q == 16'hFFFF) begin
              stuck_q     <= 1'b1;
              locked_q    <= 1'b0;
              match_q     <= '0;
              have_prev_q <= 1'b0;
              state_q     <= IDLE;
            end else begin
              lcnt_q <= lcnt_q + 16'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign highCount = high_q;
  assign lowCount  = low_q;
  assign period    = period_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign stuck     = stuck_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: two instances (TOL 0 and TOL 1) share one
// input; expected publications are queued at each rise and checked on valid.
module tb_clock_period_meter;
  localparam int SYNC = 2;
  localparam int LOCK = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic measClk = 1'b0;
  logic [15:0] hc_a, lc_a, hc_b, lc_b;
  logic [16:0] per_a, per_b;
  logic valid_a, locked_a, stuck_a, valid_b, locked_b, stuck_b;

  clock_period_meter #(.SYNC_STAGES(SYNC), .LOCK_PERIODS(LOCK), .TOL(0)) u_dut_a (
    .clk(clk), .rst(rst), .measClk(measClk),
    .highCount(hc_a), .lowCount(lc_a), .period(per_a),
    .valid(valid_a), .locked(locked_a), .stuck(stuck_a)
  );

  clock_period_meter #(.SYNC_STAGES(SYNC), .LOCK_PERIODS(LOCK), .TOL(1)) u_dut_b (
    .clk(clk), .rst(rst), .measClk(measClk),
    .highCount(hc_b), .lowCount(lc_b), .period(per_b),
    .valid(valid_b), .locked(locked_b), .stuck(stuck_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int   h;
    int   l;
    int   cyc;
    logic lk_a;
    logic lk_b;
  } exp_t;
  exp_t exp_q[$];

  // Reference lock model, index 0 = TOL 0 instance, 1 = TOL 1 instance
  int prev_h[2];
  int prev_l[2];
  int match[2];
  bit have[2];
  bit lk[2];
  bit pend_v = 1'b0;
  int pend_h = 0;
  int pend_l = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic model_pub(input int i, input int tol, input int h, input int l);
    if (!have[i]) begin
      match[i] = 0;
      have[i]  = 1'b1;
    end else if ((h - prev_h[i] <= tol) && (prev_h[i] - h <= tol) &&
                 (l - prev_l[i] <= tol) && (prev_l[i] - l <= tol)) begin
      if (match[i] < LOCK) match[i]++;
      if (match[i] == LOCK) lk[i] = 1'b1;
    end else begin
      match[i] = 0;
      lk[i]    = 1'b0;
    end
    prev_h[i] = h;
    prev_l[i] = l;
    return lk[i];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      have[i]  = 1'b0;
      match[i] = 0;
      lk[i]    = 1'b0;
    end
    pend_v = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a rising edge; it publishes the previously completed period, if any
  task automatic rise_publish();
    exp_t e;
    if (pend_v) begin
      e.h    = pend_h;
      e.l    = pend_l;
      e.cyc  = cyc + SYNC + 1;
      e.lk_a = model_pub(0, 0, pend_h, pend_l);
      e.lk_b = model_pub(1, 1, pend_h, pend_l);
      exp_q.push_back(e);
      pend_v = 1'b0;
    end
    measClk = 1'b1;
  endtask

  task automatic drive_period(input int h, input int l);
    rise_publish();
    tick(h);
    measClk = 1'b0;
    tick(l);
    pend_h = h;
    pend_l = l;
    pend_v = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (valid_a || valid_b) begin
      check("valid_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("valid_a", valid_a, 1);
        check("valid_b", valid_b, 1);
        check("highCount_a", hc_a, e.h);
        check("lowCount_a", lc_a, e.l);
        check("period_a", per_a, e.h + e.l);
        check("locked_a", locked_a, e.lk_a);
        check("highCount_b", hc_b, e.h);
        check("lowCount_b", lc_b, e.l);
        check("period_b", per_b, e.h + e.l);
        check("locked_b", locked_b, e.lk_b);
        $display("pub cyc=%0d h=%0d l=%0d period=%0d locked_a=%0b locked_b=%0b",
                 cyc, hc_a, lc_a, per_a, locked_a, locked_b);
      end
    end
  end

  initial begin
    model_clear();
    // Reset held with the input toggling
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      measClk = ~measClk;
      tick(1);
    end
    check("rst_highCount", hc_a, 0);
    check("rst_lowCount", lc_a, 0);
    check("rst_period", per_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_locked", locked_a, 0);
    check("rst_stuck", stuck_a, 0);
    check("rst_period_b", per_b, 0);
    measClk = 1'b0;
    rst = 1'b1;
    tick(2);

    // Basic period, lock, then a 4/5 switch (TOL 0 drops lock, TOL 1 keeps it)
    for (int i = 0; i < 6; i++) drive_period(3, 5);
    for (int i = 0; i < 6; i++) drive_period(4, 5);

    // Stuck high
    rise_publish();
    tick(65537);
    check("stuck_early", stuck_a, 0);
    tick(1);
    check("stuck_a", stuck_a, 1);
    check("stuck_b", stuck_b, 1);
    check("stuck_locked_a", locked_a, 0);
    check("stuck_locked_b", locked_b, 0);
    model_clear();
    tick(70000 - 65538);
    measClk = 1'b0;
    tick(4);
    drive_period(6, 3);
    check("stuck_clear_a", stuck_a, 0);
    check("stuck_clear_b", stuck_b, 0);

    // Minimum 1 high / 1 low
    for (int i = 0; i < 4; i++) drive_period(1, 1);

    // One-cycle reset during a low phase
    rise_publish();
    tick(3);
    measClk = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    check("midrst_highCount", hc_a, 0);
    check("midrst_lowCount", lc_a, 0);
    check("midrst_period", per_a, 0);
    check("midrst_locked", locked_a, 0);
    check("midrst_highCount_b", hc_b, 0);
    model_clear();
    tick(3);
    drive_period(3, 5);
    drive_period(2, 4);

    // Input high across reset release: first period starts at the genuine rise
    rise_publish();
    tick(5);
    rst = 1'b0;
    tick(2);
    model_clear();
    rst = 1'b1;
    tick(6);
    measClk = 1'b0;
    tick(3);
    drive_period(3, 5);
    drive_period(3, 5);
    rise_publish();
    tick(2);
    measClk = 1'b0;
    tick(10);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
